vram_arbiter: RTL
=================

Name: vram_arbiter

Overview:
- Arbitrates one single-port video/map RAM between the VGA pixel fetch path and N_REQ game-logic writers (player, enemies, bullets).
- The VGA read path has absolute priority and a fixed read latency.
- Writers share the remaining slots round-robin using a req/gnt handshake.
- Sits between the VGA timing/pixel pipeline and the map/sprite RAM; also flags writers starved beyond a limit.

Parameters:
- ADDR_W, 12, RAM address width.
- DATA_W, 8, RAM data width (tile/colour index).
- N_REQ, 3, number of write requesters (≥1, ≤8).
- MAX_WAIT, 1023, pending-cycle count at which a writer's starve flag sets.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- vga_active  in  1  high during visible region
- vga_req  in  1  pixel fetch request this cycle
- vga_addr  in  ADDR_W  fetch address
- vga_rdata  out  DATA_W  fetch data (= mem_rdata)
- vga_rvalid  out  1  vga_rdata valid
- wr_req  in  N_REQ  per-writer request, held until granted
- wr_addr  in  N_REQ*ADDR_W  packed addresses, writer i at [i*ADDR_W +: ADDR_W]
- wr_data  in  N_REQ*DATA_W  packed data
- wr_gnt  out  N_REQ  one-hot grant pulse
- wr_starve  out  N_REQ  sticky starve flag per writer
- mem_en  out  1  RAM enable
- mem_we  out  1  RAM write enable
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, 1-cycle latency after mem_en

Behaviour:
- Reset: all outputs 0; RR pointer = 0; wait counters = 0; in-flight read pipeline cleared.
- All outputs registered except vga_rdata, which passes mem_rdata through.
- Arbitration: sampled every clock edge with registered outputs.
  - Issue slot states: IDLE (mem_en=0), RD (mem_en=1, mem_we=0), WR (mem_en=1, mem_we=1).
  - Next state is RD if vga_req=1.
  - Else WR if a write is eligible.
  - Else IDLE.
- VGA read:
  - vga_req high in cycle k → mem_en=1, mem_addr=vga_addr(k) in cycle k+1 → vga_rvalid=1 in cycle k+2.
  - Latency is fixed at 2 and never stalled.
  - Back-to-back vga_req gives back-to-back rvalid.
- Write eligibility: vga_req=0 AND vga_active=0 (see Optional Feature) AND some unmasked wr_req bit set.
- Writer selection: first set bit searching from the RR pointer upward, wrapping modulo N_REQ.
- Write issue: in the cycle after selection, mem_we=1 and mem_addr/mem_wdata come from the selected writer. wr_gnt[i]=1 for exactly that cycle.
  - RR pointer advances to i+1 (wrapping to 0 after N_REQ-1).
- Handshake:
  - The writer holds req/addr/data stable until it samples wr_gnt high, then drops req or presents a new request.
  - A writer whose wr_gnt is high this cycle is masked from selection this cycle, so there is no double grant.
- Simultaneous vga_req and writes: VGA wins; all writes wait and their RR position is unchanged.
- Starve tracking:
  - Per writer, the counter increments each cycle wr_req[i]=1 and wr_gnt[i]=0, saturating at MAX_WAIT.
  - The counter clears on grant or when req drops.
  - wr_starve[i] sets when the counter reaches MAX_WAIT and stays set until rst.
- Reset mid-operation: a pending rvalid is dropped and any pending grant is not issued. RAM contents are untouched.
- A single writer requesting continuously during blanking is granted every other cycle (grant cycle masked).

Optional Feature:
- VRAM_ARB_ACTIVE_WRITE_EN defined: the vga_active term is removed from write eligibility, so writes use any cycle with vga_req=0 (e.g. alternate cycles at 2× pixel clock).
- Undefined: writes are confined to blanking (vga_active=0).
- VGA timing is identical in both builds.

Decomposition:
- Shared package vram_pkg: ADDR_W/DATA_W defaults and slot-state encoding (IDLE=2'd0, RD=2'd1, WR=2'd2).
- One natural sub-module, rr_pick: combinational N_REQ round-robin picker (req, mask, ptr → one-hot, valid).
- Starve counters are generated inline per writer.

Test Plan:
- vga_req high cycles 10–13, addrs 0x100–0x103; RAM preloaded with value = addr[7:0] → mem_en/mem_addr in cycles 11–14, vga_rvalid cycles 12–15 with data 0x00–0x03.
- vga_active=0, vga_req=0; wr_req=3'b111 from cycle 20 → grants 001, 010, 100 on consecutive cycles 21–23; RAM updated at each writer's address.
- wr_req[1]=1 during vga_active=1 (feature off) → no grant until vga_active falls; grant exactly 1 cycle after the fall.
- vga_req and wr_req[0] both high in cycle 30 → RD issued cycle 31; WR granted cycle 32 once vga_req drops in cycle 31.
- MAX_WAIT=15; hold wr_req[2]=1 under vga_active=1 for 20 cycles → wr_starve[2] rises after the 15th waiting cycle and stays set after the grant.
- rst pulsed in the cycle after a vga_req → vga_rvalid stays 0; all outputs 0 next cycle; RR restarts at writer 0.

Source files
------------

// File: rtl/vram_pkg.sv
// Shared definitions for the VRAM arbiter: default bus widths, issue-slot
// encoding and a small index-wrap helper used by the round-robin picker.
package vram_pkg;

  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    SLOT_IDLE = 2'd0,
    SLOT_RD   = 2'd1,
    SLOT_WR   = 2'd2
  } slot_e;

  // Wraps base+offset back into 0..n-1; offset is always below n.
  function automatic int rr_wrap(input int idx, input int n);
    return (idx >= n) ? idx - n : idx;
  endfunction

endpackage

// File: rtl/vram_arbiter_if.sv
// Bundle of VGA fetch, writer req/gnt and RAM port signals for vram_arbiter.
// The slave modport is the arbiter side, the master modport is its environment.
interface vram_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8,
  parameter int N_REQ  = 3
);
  import vram_pkg::*;

  logic                     vga_active;
  logic                     vga_req;
  logic [ADDR_W-1:0]        vga_addr;
  logic [DATA_W-1:0]        vga_rdata;
  logic                     vga_rvalid;

  // Writer handshake: wr_req[i] acts as valid and is held, together with its
  // address/data slice, until the writer sees wr_gnt[i] high for one cycle;
  // the grant is the ready/accept pulse and the write is on the RAM port in
  // that same cycle. The next cycle the writer drops req or presents new data.
  logic [N_REQ-1:0]         wr_req;
  logic [N_REQ*ADDR_W-1:0]  wr_addr;
  logic [N_REQ*DATA_W-1:0]  wr_data;
  logic [N_REQ-1:0]         wr_gnt;
  logic [N_REQ-1:0]         wr_starve;

  logic                     mem_en;
  logic                     mem_we;
  logic [ADDR_W-1:0]        mem_addr;
  logic [DATA_W-1:0]        mem_wdata;
  logic [DATA_W-1:0]        mem_rdata;

  slot_e                    dbg_slot;

  modport slave (
    input  vga_active, vga_req, vga_addr, wr_req, wr_addr, wr_data, mem_rdata,
    output vga_rdata, vga_rvalid, wr_gnt, wr_starve,
    output mem_en, mem_we, mem_addr, mem_wdata, dbg_slot
  );

  modport master (
    output vga_active, vga_req, vga_addr, wr_req, wr_addr, wr_data, mem_rdata,
    input  vga_rdata, vga_rvalid, wr_gnt, wr_starve,
    input  mem_en, mem_we, mem_addr, mem_wdata, dbg_slot
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requesting, unmasked index at or
// above ptr_i, wrapping modulo N. Returns one-hot grant, index and valid.
module rr_pick
  import vram_pkg::*;
#(
  parameter int N     = 3,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [N-1:0]     mask_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [PTR_W-1:0] idx_o,
  output logic             valid_o
);

  logic [N-1:0] elig;

  assign elig = req_i & ~mask_i;

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!valid_o && elig[rr_wrap(int'(ptr_i) + k, N)]) begin
        valid_o                              = 1'b1;
        gnt_o[rr_wrap(int'(ptr_i) + k, N)]   = 1'b1;
        idx_o                                = PTR_W'(rr_wrap(int'(ptr_i) + k, N));
      end
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: VGA reads take every slot they ask for, writers
// share the rest round-robin and get sticky starve flags. Optional build
// macro VRAM_ARB_ACTIVE_WRITE_EN lets writes use visible-region idle slots.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int N_REQ    = 3,
  parameter int MAX_WAIT = 1023
) (
  input  logic           clk,
  input  logic           rst,
  vram_arbiter_if.slave  bus
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_REQ - 1);

  slot_e               slot_q, slot_d;
  logic                mem_en_q, mem_we_q, rvalid_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic [N_REQ-1:0]    wr_gnt_q;
  logic [PTR_W-1:0]    ptr_q, ptr_d;

  logic                wr_window;
  logic                wr_go;
  logic [N_REQ-1:0]    pick_gnt;
  logic [PTR_W-1:0]    pick_idx;
  logic                pick_valid;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_data;

`ifdef VRAM_ARB_ACTIVE_WRITE_EN
  assign wr_window = 1'b1;
`else
  assign wr_window = ~bus.vga_active;
`endif

  // The writer holding this cycle's grant is masked so it cannot win twice.
  rr_pick #(
    .N     (N_REQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .req_i   (bus.wr_req),
    .mask_i  (wr_gnt_q),
    .ptr_i   (ptr_q),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  assign wr_go    = ~bus.vga_req & wr_window & pick_valid;
  assign sel_addr = bus.wr_addr[pick_idx*ADDR_W +: ADDR_W];
  assign sel_data = bus.wr_data[pick_idx*DATA_W +: DATA_W];
  assign ptr_d    = (pick_idx == PTR_LAST) ? '0 : pick_idx + PTR_W'(1);

  always_comb begin
    slot_d = SLOT_IDLE;
    if (bus.vga_req) begin
      slot_d = SLOT_RD;
    end else if (wr_go) begin
      slot_d = SLOT_WR;
    end
  end

  // rvalid follows one cycle behind a RD slot, matching the RAM's read latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q      <= SLOT_IDLE;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      wr_gnt_q    <= '0;
      ptr_q       <= '0;
      rvalid_q    <= 1'b0;
    end else begin
      slot_q   <= slot_d;
      mem_en_q <= (slot_d != SLOT_IDLE);
      mem_we_q <= (slot_d == SLOT_WR);
      rvalid_q <= (slot_q == SLOT_RD);
      wr_gnt_q <= '0;
      case (slot_d)
        SLOT_RD: begin
          mem_addr_q <= bus.vga_addr;
        end
        SLOT_WR: begin
          mem_addr_q  <= sel_addr;
          mem_wdata_q <= sel_data;
          wr_gnt_q    <= pick_gnt;
          ptr_q       <= ptr_d;
        end
        default: begin
        end
      endcase
    end
  end

  for (genvar g = 0; g < N_REQ; g++) begin : g_starve
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             starve_q;

    always_comb begin
      cnt_d = cnt_q;
      if (!bus.wr_req[g] || wr_gnt_q[g]) begin
        cnt_d = '0;
      end else if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q    <= '0;
        starve_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        if (cnt_d == CNT_MAX) begin
          starve_q <= 1'b1;
        end
      end
    end

    assign bus.wr_starve[g] = starve_q;
  end

  assign bus.vga_rdata  = bus.mem_rdata;
  assign bus.vga_rvalid = rvalid_q;
  assign bus.wr_gnt     = wr_gnt_q;
  assign bus.mem_en     = mem_en_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.dbg_slot   = slot_q;

endmodule
